// File: rtl/stk_pipe_sch.sv
`default_nettype none
// ============================================================================
// Module      : stk_pipe_sch
// Description : Command scheduler at the head of the stack pipeline. Shares
//               the single pipeline between ENGS_N engines using round-robin
//               arbitration, with at most one in-flight command per engine.
//               PUSH is only granted while the allocator can supply a
//               pointer. The winning command is registered into the LK stage.
//               Optional starvation override: define STK_PIPE_SCH_STARVE_EN.
// Ports       : clk, rst               clock / synchronous active-high reset
//               i_cmd_opcode/i_cmd_dat per-engine command (NOP = no request)
//               o_cmd_ack              one-hot same-cycle accept
//               i_al_empty_r/i_al_busy allocator status, o_al_alloc strobe
//               i_rsp_vld              per-engine retire
//               o_lk_*_r               registered LK-stage command
//               o_eng_busy_r           per-engine in-flight flag
// Revision    : 1.0  initial release
// ============================================================================
module stk_pipe_sch #(
    parameter int ENGS_N   = 4,
    parameter int OPC_W    = 2,
    parameter int DAT_W    = 128,
    parameter int STARVE_N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ENGS_N*OPC_W-1:0]    i_cmd_opcode,
    input  logic [ENGS_N*DAT_W-1:0]    i_cmd_dat,
    output logic [ENGS_N-1:0]          o_cmd_ack,
    input  logic                       i_al_empty_r,
    input  logic                       i_al_busy,
    output logic                       o_al_alloc,
    input  logic [ENGS_N-1:0]          i_rsp_vld,
    output logic                       o_lk_vld_r,
    output logic [$clog2(ENGS_N)-1:0]  o_lk_engid_r,
    output logic [OPC_W-1:0]           o_lk_opcode_r,
    output logic                       o_lk_dat_vld_r,
    output logic [DAT_W-1:0]           o_lk_dat_r,
    output logic [ENGS_N-1:0]          o_eng_busy_r
);

    localparam int             c_ID_W     = $clog2(ENGS_N);
    localparam logic [OPC_W-1:0] c_OPC_NOP  = '0;
    localparam logic [OPC_W-1:0] c_OPC_PUSH = OPC_W'(1);

    // Elaboration-time parameter sanity checks.
    if (ENGS_N < 2) begin : g_bad_engs
        $error("stk_pipe_sch: ENGS_N must be >= 2");
    end
    if (STARVE_N < 1) begin : g_bad_starve
        $error("stk_pipe_sch: STARVE_N must be >= 1");
    end

    logic [c_ID_W-1:0] r_rr_ptr;
    logic [ENGS_N-1:0] w_req;
    logic [ENGS_N-1:0] w_elig;
    logic              w_gnt_vld;
    logic [c_ID_W-1:0] w_gnt_id;
    logic [ENGS_N-1:0] w_gnt_oh;
    logic [OPC_W-1:0]  w_gnt_opc;
    logic [DAT_W-1:0]  w_gnt_dat;
    logic              w_push_ok;

    assign w_push_ok = !i_al_empty_r && !i_al_busy;

    // A request exists whenever an idle engine presents a non-NOP opcode;
    // eligibility additionally blocks PUSH while the allocator cannot serve it.
    always_comb begin
        w_req  = '0;
        w_elig = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            w_req[e]  = (i_cmd_opcode[e*OPC_W +: OPC_W] != c_OPC_NOP) && !o_eng_busy_r[e];
            w_elig[e] = w_req[e] &&
                        ((i_cmd_opcode[e*OPC_W +: OPC_W] != c_OPC_PUSH) || w_push_ok);
        end
    end

`ifdef STK_PIPE_SCH_STARVE_EN
    localparam int c_CNT_W = $clog2(STARVE_N + 1);
    logic [c_CNT_W-1:0] r_starve [ENGS_N];
`endif

    // Arbiter: first eligible engine scanning upward from r_rr_ptr (mod N).
    always_comb begin
        logic [c_ID_W:0] w_sum;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        for (int k = 0; k < ENGS_N; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_ID_W+1)'(k);
            if (w_sum >= (c_ID_W+1)'(ENGS_N)) begin
                w_sum = w_sum - (c_ID_W+1)'(ENGS_N);
            end
            if (!w_gnt_vld && w_elig[w_sum[c_ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_sum[c_ID_W-1:0];
            end
        end
`ifdef STK_PIPE_SCH_STARVE_EN
        // Starved eligible engines pre-empt round-robin; descending scan so
        // the lowest index is the one left standing.
        for (int e = ENGS_N - 1; e >= 0; e--) begin
            if (w_elig[e] && (r_starve[e] >= c_CNT_W'(STARVE_N))) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = c_ID_W'(e);
            end
        end
`endif
        if (rst) begin
            w_gnt_vld = 1'b0;
        end
    end

    assign w_gnt_oh   = w_gnt_vld ? (ENGS_N'(1) << w_gnt_id) : '0;
    assign w_gnt_opc  = i_cmd_opcode[w_gnt_id*OPC_W +: OPC_W];
    assign w_gnt_dat  = i_cmd_dat[w_gnt_id*DAT_W +: DAT_W];
    assign o_cmd_ack  = w_gnt_oh;
    assign o_al_alloc = w_gnt_vld && (w_gnt_opc == c_OPC_PUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            o_lk_vld_r     <= 1'b0;
            o_lk_engid_r   <= '0;
            o_lk_opcode_r  <= '0;
            o_lk_dat_vld_r <= 1'b0;
            o_lk_dat_r     <= '0;
            o_eng_busy_r   <= '0;
        end else begin
            o_lk_vld_r <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr_ptr       <= (w_gnt_id == c_ID_W'(ENGS_N - 1)) ? '0 : w_gnt_id + 1'b1;
                o_lk_engid_r   <= w_gnt_id;
                o_lk_opcode_r  <= w_gnt_opc;
                o_lk_dat_vld_r <= (w_gnt_opc == c_OPC_PUSH);
                if (w_gnt_opc == c_OPC_PUSH) begin
                    o_lk_dat_r <= w_gnt_dat;
                end
            end
            // Per-engine IDLE/BUSY state; a response on an idle engine has no
            // effect because the mask only clears bits that are already set.
            o_eng_busy_r <= (o_eng_busy_r & ~i_rsp_vld) | w_gnt_oh;
        end
    end

`ifdef STK_PIPE_SCH_STARVE_EN
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENGS_N; e++) begin
            if (rst || !w_req[e] || w_gnt_oh[e]) begin
                r_starve[e] <= '0;
            end else if (r_starve[e] != c_CNT_W'(STARVE_N)) begin
                r_starve[e] <= r_starve[e] + 1'b1;
            end
        end
    end
`endif

    a_rsp_on_idle : assert property (@(posedge clk) disable iff (rst)
        !(|(i_rsp_vld & ~o_eng_busy_r)))
        else $warning("stk_pipe_sch: response on idle engine ignored, mask=%b",
                      i_rsp_vld & ~o_eng_busy_r);

endmodule
`default_nettype wire

// File: tb/tb_stk_pipe_sch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stk_pipe_sch
// Description : Directed self-checking bench for stk_pipe_sch (4 engines,
//               2-bit opcodes, 128-bit data). The starvation scenario runs
//               only when STK_PIPE_SCH_STARVE_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stk_pipe_sch;

    localparam int ENGS_N = 4;
    localparam int OPC_W  = 2;
    localparam int DAT_W  = 128;

    localparam logic [1:0] c_NOP  = 2'd0;
    localparam logic [1:0] c_PUSH = 2'd1;
    localparam logic [1:0] c_POP  = 2'd2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [ENGS_N*OPC_W-1:0]   cmd_opcode;
    logic [ENGS_N*DAT_W-1:0]   cmd_dat;
    logic [ENGS_N-1:0]         cmd_ack;
    logic                      al_empty_r;
    logic                      al_busy;
    logic                      al_alloc;
    logic [ENGS_N-1:0]         rsp_vld;
    logic                      lk_vld_r;
    logic [1:0]                lk_engid_r;
    logic [OPC_W-1:0]          lk_opcode_r;
    logic                      lk_dat_vld_r;
    logic [DAT_W-1:0]          lk_dat_r;
    logic [ENGS_N-1:0]         eng_busy_r;

    int n_cmp = 0;
    int n_bad = 0;

    stk_pipe_sch #(
        .ENGS_N   (ENGS_N),
        .OPC_W    (OPC_W),
        .DAT_W    (DAT_W),
        .STARVE_N (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_opcode   (cmd_opcode),
        .i_cmd_dat      (cmd_dat),
        .o_cmd_ack      (cmd_ack),
        .i_al_empty_r   (al_empty_r),
        .i_al_busy      (al_busy),
        .o_al_alloc     (al_alloc),
        .i_rsp_vld      (rsp_vld),
        .o_lk_vld_r     (lk_vld_r),
        .o_lk_engid_r   (lk_engid_r),
        .o_lk_opcode_r  (lk_opcode_r),
        .o_lk_dat_vld_r (lk_dat_vld_r),
        .o_lk_dat_r     (lk_dat_r),
        .o_eng_busy_r   (eng_busy_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int e, input logic [1:0] op);
        cmd_opcode[e*OPC_W +: OPC_W] = op;
    endtask

    task automatic set_all(input logic [1:0] op);
        for (int e = 0; e < ENGS_N; e++) cmd_opcode[e*OPC_W +: OPC_W] = op;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        // ---------------- reset with all engines requesting ----------------
        rst        = 1'b1;
        cmd_dat    = '0;
        al_empty_r = 1'b0;
        al_busy    = 1'b0;
        rsp_vld    = '0;
        set_all(c_POP);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_lk_vld", 128'(lk_vld_r), 128'd0);
            chk("rst_busy", 128'(eng_busy_r), 128'd0);
            settle();
            chk("rst_ack", 128'(cmd_ack), 128'd0);
            chk("rst_alloc", 128'(al_alloc), 128'd0);
        end
        chk("rst_engid", 128'(lk_engid_r), 128'd0);
        chk("rst_dat", lk_dat_r, 128'd0);

        // ---------------- round robin with POPs, rsp one cycle later -------
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rsp_vld = (i == 0) ? 4'b0000 : 4'(1 << exp_order[i-1]);
            settle();
            chk("rr_ack", 128'(cmd_ack), 128'(1 << exp_order[i]));
            chk("rr_alloc", 128'(al_alloc), 128'd0);
            tick();
            chk("rr_lk_vld", 128'(lk_vld_r), 128'd1);
            chk("rr_lk_engid", 128'(lk_engid_r), 128'(exp_order[i]));
            chk("rr_lk_opc", 128'(lk_opcode_r), 128'(c_POP));
        end
        chk("rr_dat_vld", 128'(lk_dat_vld_r), 128'd0);
        // Quiesce: retire engine 0, nobody requests.
        set_all(c_NOP);
        rsp_vld = 4'b0001;
        settle();
        chk("idle_ack", 128'(cmd_ack), 128'd0);
        tick();
        chk("idle_lk_vld", 128'(lk_vld_r), 128'd0);
        chk("idle_engid_hold", 128'(lk_engid_r), 128'd0);
        chk("idle_busy", 128'(eng_busy_r), 128'd0);

        // ---------------- PUSH blocked by empty allocator (rr_ptr=1) -------
        rsp_vld = '0;
        set_op(2, c_PUSH);
        cmd_dat[2*DAT_W +: DAT_W] = 128'hA5;
        al_empty_r = 1'b1;
        settle();
        chk("empty_ack", 128'(cmd_ack), 128'd0);
        chk("empty_alloc", 128'(al_alloc), 128'd0);
        tick();
        chk("empty_lk_vld", 128'(lk_vld_r), 128'd0);
        al_empty_r = 1'b0;
        settle();
        chk("push_ack", 128'(cmd_ack), 128'b0100);
        chk("push_alloc", 128'(al_alloc), 128'd1);
        tick();
        chk("push_lk_vld", 128'(lk_vld_r), 128'd1);
        chk("push_lk_engid", 128'(lk_engid_r), 128'd2);
        chk("push_lk_opc", 128'(lk_opcode_r), 128'(c_PUSH));
        chk("push_dat_vld", 128'(lk_dat_vld_r), 128'd1);
        chk("push_dat", lk_dat_r, 128'hA5);
        chk("push_busy", 128'(eng_busy_r), 128'b0100);
        set_op(2, c_NOP);
        rsp_vld = 4'b0100;
        tick();
        chk("push_retire", 128'(eng_busy_r), 128'd0);
        chk("dat_hold", lk_dat_r, 128'hA5);

        // ---------------- wrap: rr_ptr=3, engines 3 and 0 request ----------
        rsp_vld = '0;
        set_op(3, c_POP);
        set_op(0, c_POP);
        settle();
        chk("wrap_ack3", 128'(cmd_ack), 128'b1000);
        tick();
        rsp_vld = 4'b1000;  // engine 3 still requesting but busy this cycle
        settle();
        chk("wrap_ack0", 128'(cmd_ack), 128'b0001);
        tick();
        chk("wrap_engid", 128'(lk_engid_r), 128'd0);
        chk("wrap_busy", 128'(eng_busy_r), 128'b0001);
        // Stray response on idle engine 2 together with engine 0's retire.
        set_all(c_NOP);
        rsp_vld = 4'b0101;
        tick();
        chk("stray_busy", 128'(eng_busy_r), 128'd0);
        chk("stray_lk_vld", 128'(lk_vld_r), 128'd0);

        // ---------------- engine 1 held in flight (rr_ptr=1) ---------------
        rsp_vld = '0;
        set_op(1, c_POP);
        settle();
        chk("hold_first_ack", 128'(cmd_ack), 128'b0010);
        tick();
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("hold_no_ack", 128'(cmd_ack), 128'd0);
            tick();
        end
        rsp_vld = 4'b0010;
        settle();
        chk("hold_rsp_cycle", 128'(cmd_ack), 128'd0);
        tick();
        rsp_vld = '0;
        settle();
        chk("hold_reack", 128'(cmd_ack), 128'b0010);
        tick();
        set_all(c_NOP);
        rsp_vld = 4'b0010;
        tick();
        chk("hold_retire", 128'(eng_busy_r), 128'd0);

`ifdef STK_PIPE_SCH_STARVE_EN
        // ---------------- starvation override (STARVE_N=2) -----------------
        // Engine 2 in flight, engine 1 POP granted so rr_ptr lands on 2.
        rsp_vld = '0;
        set_op(2, c_POP);
        settle();
        chk("stv_ack2", 128'(cmd_ack), 128'b0100);
        tick();
        set_op(1, c_POP);
        settle();
        chk("stv_ack1", 128'(cmd_ack), 128'b0010);
        tick();
        // Engine 1 retires and switches to a PUSH blocked by allocator busy.
        rsp_vld = 4'b0010;
        set_op(1, c_PUSH);
        cmd_dat[1*DAT_W +: DAT_W] = 128'h5A;
        al_busy = 1'b1;
        settle();
        chk("stv_none0", 128'(cmd_ack), 128'd0);
        tick();
        rsp_vld = '0;
        settle();
        chk("stv_blk1", 128'(cmd_ack), 128'd0);
        tick();
        rsp_vld = 4'b0100;
        settle();
        chk("stv_blk2", 128'(cmd_ack), 128'd0);
        tick();
        // Allocator free: round robin would pick engine 2, starvation picks 1.
        rsp_vld = '0;
        al_busy = 1'b0;
        settle();
        chk("stv_override", 128'(cmd_ack), 128'b0010);
        chk("stv_alloc", 128'(al_alloc), 128'd1);
        tick();
        chk("stv_dat", lk_dat_r, 128'h5A);
        set_op(1, c_NOP);
        settle();
        chk("stv_next", 128'(cmd_ack), 128'b0100);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
